sevenseg_scan: RTL and testbench
================================

# sevenseg_scan

Time-multiplexed scan controller for a bank of seven-segment digits sharing one `sevenseg` decoder. It holds a packed multi-digit hex value, presents one 4-bit digit code at a time to the decoder's `data` input, and drives the matching active-low digit anode. A blanking gap between digits prevents ghosting. New display values are double-buffered so a frame is never torn.

## Interface
- `NDIG`, 4: number of digits, 2..8.
- `DWELL`, 1000: clock cycles each digit is lit, at least 1.
- `GAP`, 2: all-anodes-off cycles after each digit, at least 0.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  scan enable; low forces OFF.
- `load`  in  1  one-cycle strobe that captures `din` into the shadow register.
- `din`  in  4*NDIG  packed digit codes; digit k is `din[4k+3:4k]`.
- `blank`  in  NDIG  per-digit blank; 1 keeps that anode off.
- `data`  out  4  digit code to the `sevenseg` decoder.
- `an`  out  NDIG  active-low anodes; at most one bit is 0.
- `frame`  out  1  one-cycle pulse at the start of each repeated frame.
- `pending`  out  1  shadow holds a value not yet displayed.

## Operation
- **Reset values:**
  - State OFF; idx 0; counter 0.
  - shadow 0; active 0; blank_q 0.
  - Outputs: `an` all ones, `data` 0, `frame` 0, `pending` 0.
- **Registered inputs and output decode:**
  - `blank` is registered into blank_q every cycle.
  - `an` and `data` are decoded combinationally from registers only (state, idx, active, blank_q).
- **OFF:**
  - `an` all ones; `data` = active[idx].
  - `en`=1 moves to SHOW with idx 0 and counter 0, and commits shadow if `pending`.
- **SHOW:**
  - `an[idx]` = ~(~blank_q[idx]); all other anode bits are 1.
  - `data` = active[4*idx+3:4*idx].
  - counter runs 0..DWELL-1.
  - At DWELL-1 the counter clears and the state moves to GAP. If GAP=0 it goes straight to the advance step.
- **GAP:**
  - `an` all ones; `data` holds.
  - Lasts GAP cycles, then the advance step runs.
- **Advance step:**
  - If idx<NDIG-1: idx+1, enter SHOW.
  - If idx=NDIG-1: idx 0, enter SHOW, `frame`=1 for the next cycle, and commit shadow if `pending` (frame boundary).
- **Commit:** active <= shadow; `pending` <= 0.
- **Load:**
  - `load`=1 sets shadow <= `din` and `pending` <= 1.
  - Load on a commit cycle: active <= `din`, shadow <= `din`, `pending` <= 0 (the new value bypasses the shadow).
  - Repeated loads before a boundary: the last one wins.
- **Enable drop:** `en`=0 in any state moves to OFF on the next edge, with idx and counter cleared. shadow and `pending` are retained.
- **Mid-operation reset:** all registers return immediately to their reset values; a pending load is lost.

## Timing
- Frame period is NDIG*(DWELL+GAP) cycles, with no extra cycles at the frame boundary.
- Enable path:
  - `en` rises before edge E: SHOW digit 0 from edge E.
  - Its anode goes low in the cycle after E, provided blank_q=0.
- `frame`:
  - High in the first SHOW cycle of digit 0 of every frame after the first.
  - Not asserted on entry from OFF.
- Load-to-display latency: a value loaded mid-frame appears in the first SHOW cycle of the next frame.
- `blank` change reaches `an` one cycle later.
- `an` is never low for two digits in the same cycle. With GAP≥1, at least GAP all-ones cycles separate any two lit digits.

## Test plan
All scenarios use NDIG=4, DWELL=4, GAP=1 (frame = 20 cycles).
- **Reset and enable:** reset, then `en`=1 → `an` steps 1110(4 cycles),1111,1101(4),1111,1011(4),1111,0111(4),1111. `data` = active digits 0..3. The next 1110 coincides with `frame`=1.
- **Mid-frame load:** `load` with `din`=16'h1234 while digit 1 is lit → `pending`=1 and the current frame still shows old digits. At the next boundary `data` goes 4,3,2,1 across digits 0..3 and `pending`=0.
- **Simultaneous load and commit:** `load` 16'hABCD on the boundary cycle after an earlier load of 16'h5555 → the next frame shows D,C,B,A and `pending`=0.
- **Blanking:** `blank`=4'b0100 → during digit 2's dwell `an`=1111 while `data`=active digit 2. Other digits are unaffected.
- **Enable drop and reset:** drop `en` during digit 2 → `an`=1111 on the next cycle. Re-enable → scanning restarts at digit 0 with no `frame` pulse. Assert `reset` mid-SHOW → `an`=1111 and `data`=0 asynchronously.
- **GAP=0 build:** anodes step 1110→1101 with no all-ones cycle, and the frame period is 16 cycles.

Source files
------------

// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment scan controller with double-buffered display value
// and a blanking gap between digits.
module sevenseg_scan #(
    parameter int unsigned NDIG  = 4,
    parameter int unsigned DWELL = 1000,
    parameter int unsigned GAP   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] din,
    input  logic [NDIG-1:0]   blank,
    output logic [3:0]        data,
    output logic [NDIG-1:0]   an,
    output logic              frame,
    output logic              pending
);

    localparam int unsigned IW   = $clog2(NDIG);
    localparam int unsigned CMAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
    localparam logic [CW-1:0] DEND     = CW'(DWELL - 1);
    localparam logic [CW-1:0] GEND     = CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SHOW,
        ST_GAP
    } state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [4*NDIG-1:0] shadow, active;
    logic [NDIG-1:0]   blank_q;
    logic              advance, wrap, commit;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_OFF;
        else       state <= state_nxt;
    end

    // Next-state, digit index and dwell/gap counter; commit marks a frame boundary
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        advance   = 1'b0;
        wrap      = 1'b0;
        commit    = 1'b0;

        if (!en) begin
            state_nxt = ST_OFF;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nxt = ST_SHOW;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    commit    = 1'b1;
                end
                ST_SHOW: begin
                    if (cnt == DEND) begin
                        cnt_nxt = '0;
                        if (GAP == 0) advance = 1'b1;
                        else          state_nxt = ST_GAP;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == GEND) begin
                        cnt_nxt = '0;
                        advance = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: state_nxt = ST_OFF;
            endcase

            if (advance) begin
                state_nxt = ST_SHOW;
                if (idx == IDX_LAST) begin
                    idx_nxt = '0;
                    wrap    = 1'b1;
                    commit  = 1'b1;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
        end
    end

    // Anode and digit-code decode from registers only
    always_comb begin
        an   = '1;
        data = active[{idx, 2'b00} +: 4];
        if (state == ST_SHOW) an[idx] = blank_q[idx];
    end

    // Datapath: scan position, double-buffered value, frame strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx     <= '0;
            cnt     <= '0;
            shadow  <= '0;
            active  <= '0;
            blank_q <= '0;
            pending <= 1'b0;
            frame   <= 1'b0;
        end else begin
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            blank_q <= blank;
            frame   <= wrap;
            if (load) shadow <= din;
            if (commit) begin
                pending <= 1'b0;
                if (load)         active <= din;
                else if (pending) active <= shadow;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: a time-position reference model predicts each
// cycle's outputs for a GAP=1 and a GAP=0 instance; a monitor compares on negedge.
module tb_sevenseg_scan;

    localparam int NDIG  = 4;
    localparam int DWELL = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] data;
        logic       frame;
        logic       pending;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  blank = '0;

    logic [3:0] data0, an0, data1, an1;
    logic       frame0, pend0, frame1, pend1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    sevenseg_scan #(.NDIG(NDIG), .DWELL(DWELL), .GAP(1)) u0 (
        .clk(clk), .reset(reset), .en(en), .load(load), .din(din), .blank(blank),
        .data(data0), .an(an0), .frame(frame0), .pending(pend0)
    );

    sevenseg_scan #(.NDIG(NDIG), .DWELL(DWELL), .GAP(0)) u1 (
        .clk(clk), .reset(reset), .en(en), .load(load), .din(din), .blank(blank),
        .data(data1), .an(an1), .frame(frame1), .pending(pend1)
    );

    always #5 clk = ~clk;

    // Reference model state, one slot per instance
    bit          running [2];
    int          t       [2];
    logic [15:0] act     [2];
    logic [15:0] shd     [2];
    bit          pend    [2];
    logic [3:0]  blk     [2];
    exp_t        q0[$];
    exp_t        q1[$];

    task automatic check(input string nm, input logic [7:0] a, input logic [7:0] x);
        n_tests++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
        end
    endtask

    // Outputs follow from the time elapsed since scanning started
    task automatic model_step(input int g, input int gapc, output exp_t e);
        int per, slot, pos, dig;
        bit commit, fr, lit;
        per    = NDIG * (DWELL + gapc);
        slot   = DWELL + gapc;
        commit = 0;
        fr     = 0;
        if (!en) begin
            running[g] = 0;
        end else if (!running[g]) begin
            running[g] = 1;
            t[g]       = 0;
            commit     = 1;
        end else begin
            t[g] = t[g] + 1;
            if (t[g] % per == 0) begin
                commit = 1;
                fr     = 1;
            end
        end
        if (commit) begin
            if (load) begin
                act[g] = din;
                shd[g] = din;
            end else if (pend[g]) begin
                act[g] = shd[g];
            end
            pend[g] = 0;
        end else if (load) begin
            shd[g]  = din;
            pend[g] = 1;
        end
        blk[g] = blank;

        pos = running[g] ? (t[g] % per) : 0;
        dig = pos / slot;
        lit = running[g] && ((pos % slot) < DWELL);
        e.an = 4'hf;
        if (lit && !blk[g][dig]) e.an[dig] = 1'b0;
        e.data    = act[g][4*dig +: 4];
        e.frame   = fr;
        e.pending = pend[g];
    endtask

    always @(posedge clk or posedge reset) begin
        exp_t e0, e1;
        if (reset) begin
            for (int g = 0; g < 2; g++) begin
                running[g] = 0;
                t[g]       = 0;
                act[g]     = '0;
                shd[g]     = '0;
                pend[g]    = 0;
                blk[g]     = '0;
            end
            e0 = '{an: 4'hf, data: 4'h0, frame: 1'b0, pending: 1'b0};
            q0.delete();
            q1.delete();
            q0.push_back(e0);
            q1.push_back(e0);
        end else begin
            model_step(0, 1, e0);
            model_step(1, 0, e1);
            q0.push_back(e0);
            q1.push_back(e1);
        end
    end

    // Monitor: compare every presented output cycle against the queued prediction
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            n_pops++;
            check("g1_an",      8'(an0),    8'(e.an));
            check("g1_data",    8'(data0),  8'(e.data));
            check("g1_frame",   8'(frame0), 8'(e.frame));
            check("g1_pending", 8'(pend0),  8'(e.pending));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("g0_an",      8'(an1),    8'(e.an));
            check("g0_data",    8'(data1),  8'(e.data));
            check("g0_frame",   8'(frame1), 8'(e.frame));
            check("g0_pending", 8'(pend1),  8'(e.pending));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bit found;
        run(3);
        reset = 1'b0;
        run(2);

        // Scan two frames of the reset value, then load a known value
        en = 1'b1;
        run(40);
        load = 1'b1; din = 16'hFEDC; tick(); load = 1'b0;
        run(25);

        // Mid-frame load while digit 1 is lit
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (running[0] && ((t[0] % 20) == 6)) found = 1;
            else tick();
        end
        check("wait_digit1", 8'(found), 8'd1);
        load = 1'b1; din = 16'h1234; tick(); load = 1'b0;
        run(30);

        // Earlier load then a load on the boundary cycle itself
        load = 1'b1; din = 16'h5555; tick(); load = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (running[0] && (((t[0] + 1) % 20) == 0)) found = 1;
            else tick();
        end
        check("wait_boundary", 8'(found), 8'd1);
        load = 1'b1; din = 16'hABCD; tick(); load = 1'b0;
        run(25);

        // Blank digit 2, then random blanks
        blank = 4'b0100;
        run(25);
        blank = 4'(($urandom));
        run(20);
        blank = 4'b0000;

        // Enable drop during digit 2 lit, then restart
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (running[0] && ((t[0] % 20) >= 10) && ((t[0] % 20) <= 12)) found = 1;
            else tick();
        end
        check("wait_digit2", 8'(found), 8'd1);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(30);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            en   = ($urandom_range(0, 24) != 0);
            load = ($urandom_range(0, 9) == 0);
            din  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) blank = 4'($urandom);
            tick();
        end
        load = 1'b0; blank = 4'b0000; en = 1'b1;
        run(30);

        // Asynchronous reset while a digit is lit
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (running[0] && ((t[0] % 5) < 3) && (an0 != 4'hf)) found = 1;
            else tick();
        end
        check("wait_lit", 8'(found), 8'd1);
        reset = 1'b1;
        #1;
        check("async_rst_an",   8'(an0),   8'hf);
        check("async_rst_data", 8'(data0), 8'h0);
        check("async_rst_pend", 8'(pend0), 8'h0);
        run(2);
        reset = 1'b0;
        run(45);

        check("enough_cycles", 8'(n_pops >= 500), 8'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
